// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM Wishbone register bank: offsets, CTRL bit positions, defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pwm_pkg;

  localparam int PWM_NUM_CH_DEF = 8;
  localparam int PWM_CNT_W_DEF  = 16;

  // Byte offsets from the slave base address
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_PERIOD = 8'h04;
  localparam logic [7:0] OFF_UPDATE = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_DUTY0  = 8'h10;

  // CTRL bit positions
  localparam int CTRL_GEN       = 0;
  localparam int CTRL_IMM       = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int CTRL_CH_EN_LSB = 8;

  // Commit sequencer: idle, or armed and waiting for a period boundary
  typedef enum logic {
    CM_IDLE  = 1'b0,
    CM_ARMED = 1'b1
  } commit_state_e;

  // Expand Wishbone byte selects into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/pwm_shadow_reg.sv
// One shadow/active register pair: CPU writes the shadow, load copies it (optionally clamped) to active.
// Latency: shadow updates on the write edge, active on the load edge.
// Backpressure: none; write and load are single-cycle strobes.
module pwm_shadow_reg #(
  parameter int CNT_W    = 16,
  parameter bit CLAMP_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_mask_i,
  input  logic [CNT_W-1:0] wr_dat_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] shadow_o,
  output logic [CNT_W-1:0] active_o
);

  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] clamped;

  // Byte-masked shadow merge and clamped copy toward the active value
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en_i) begin
      shadow_d = (shadow_q & ~wr_mask_i) | (wr_dat_i & wr_mask_i);
    end
    clamped = shadow_q;
    if (CLAMP_EN && (shadow_q > limit_i)) begin
      clamped = limit_i;
    end
    active_d = load_i ? clamped : active_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;

endmodule

// File: rtl/pwm_wb_regfile.sv
// Wishbone register bank for the PWM core with double-buffered period/duty and commit IRQ (PWM_WB_IRQ_EN).
// Latency: ack one cycle after hit; commit applies on the edge where armed and a period boundary coincide.
// Backpressure: one access per two cycles (ack blocks re-hit); out-of-window accesses are never acked.
module pwm_wb_regfile
  import pwm_pkg::*;
#(
  parameter int          NUM_CH    = PWM_NUM_CH_DEF,
  parameter int          CNT_W     = PWM_CNT_W_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [31:0]             wbs_adr_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic                    period_end_i,
  output logic [CNT_W-1:0]        period_o,
  output logic [NUM_CH*CNT_W-1:0] duty_o,
  output logic [NUM_CH-1:0]       ch_en_o,
  output logic                    irq_o
);

  localparam logic [31:0] CH_MASK = 32'(((1 << NUM_CH) - 1) << CTRL_CH_EN_LSB);
`ifdef PWM_WB_IRQ_EN
  localparam logic [31:0] IRQ_MASK = 32'(1) << CTRL_IRQ_EN;
`else
  localparam logic [31:0] IRQ_MASK = 32'h0;
`endif
  localparam logic [31:0] CTRL_MASK = CH_MASK | IRQ_MASK |
                                      (32'(1) << CTRL_GEN) | (32'(1) << CTRL_IMM);

  logic                   ack_q;
  logic [31:0]            dat_q, dat_d;
  logic [31:0]            ctrl_q, ctrl_d;
  logic                   done_q, done_d;
  logic [NUM_CH-1:0]      ch_en_q;
  commit_state_e          cm_q;

  logic                   hit, wr, rd;
  logic [7:0]             off;
  logic [31:0]            bmask;
  logic                   gen, imm, arm, w1c, commit, load;
  logic [CNT_W-1:0]       period_sh, period_act;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_sh, duty_act;
  logic [31:0]            rdata;

  assign hit   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign wr    = hit & wbs_we_i;
  assign rd    = hit & ~wbs_we_i;
  assign off   = wbs_adr_i[7:0];
  assign bmask = byte_mask(wbs_sel_i);
  assign gen   = ctrl_q[CTRL_GEN];
  assign imm   = ctrl_q[CTRL_IMM];
  assign arm   = wr & (off == OFF_UPDATE) & wbs_sel_i[0] & wbs_dat_i[0];
  assign w1c   = wr & (off == OFF_STATUS) & wbs_sel_i[0] & wbs_dat_i[0];
  // With the generator stopped there is no boundary to wait for, so an armed commit goes at once
  assign commit = (cm_q == CM_ARMED) & ~imm & (period_end_i | ~gen);
  assign load   = commit | imm;

  pwm_shadow_reg #(.CNT_W(CNT_W), .CLAMP_EN(1'b0)) u_period (
    .clk_i     (wb_clk_i),
    .rst_n_i   (wb_rst_n_i),
    .wr_en_i   (wr & (off == OFF_PERIOD)),
    .wr_mask_i (bmask[CNT_W-1:0]),
    .wr_dat_i  (wbs_dat_i[CNT_W-1:0]),
    .load_i    (load),
    .limit_i   (period_sh),
    .shadow_o  (period_sh),
    .active_o  (period_act)
  );

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_duty
    // Duty clamps against the period shadow that is copied on the same edge
    pwm_shadow_reg #(.CNT_W(CNT_W), .CLAMP_EN(1'b1)) u_duty (
      .clk_i     (wb_clk_i),
      .rst_n_i   (wb_rst_n_i),
      .wr_en_i   (wr & (off == (OFF_DUTY0 + 8'(4 * ch)))),
      .wr_mask_i (bmask[CNT_W-1:0]),
      .wr_dat_i  (wbs_dat_i[CNT_W-1:0]),
      .load_i    (load),
      .limit_i   (period_sh),
      .shadow_o  (duty_sh[ch]),
      .active_o  (duty_act[ch])
    );
    assign duty_o[ch*CNT_W +: CNT_W] = duty_act[ch];
  end

  // Read mux, CTRL write merge and sticky DONE next-state
  always_comb begin
    rdata = 32'h0;
    case (off)
      OFF_CTRL:   rdata = ctrl_q;
      OFF_PERIOD: rdata = 32'(period_sh);
      OFF_UPDATE: rdata = {31'b0, cm_q == CM_ARMED};
      OFF_STATUS: rdata = {30'b0, cm_q == CM_ARMED, done_q};
      default:    rdata = 32'h0;
    endcase
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (off == (OFF_DUTY0 + 8'(4 * ch))) rdata = 32'(duty_sh[ch]);
    end
    dat_d = rd ? rdata : 32'h0;

    ctrl_d = ctrl_q;
    if (wr && (off == OFF_CTRL)) begin
      ctrl_d = (ctrl_q & ~bmask) | (wbs_dat_i & bmask & CTRL_MASK);
    end

    // A commit on the same edge as a W1C keeps DONE set
    done_d = done_q;
    if (w1c)    done_d = 1'b0;
    if (commit) done_d = 1'b1;
  end

  // Bus handshake, control registers and the commit sequencer
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'h0;
      ctrl_q  <= 32'h0;
      done_q  <= 1'b0;
      ch_en_q <= '0;
      cm_q    <= CM_IDLE;
    end else begin
      ack_q   <= hit;
      dat_q   <= dat_d;
      ctrl_q  <= ctrl_d;
      done_q  <= done_d;
      ch_en_q <= ctrl_q[CTRL_CH_EN_LSB +: NUM_CH] & {NUM_CH{gen}};
      case (cm_q)
        CM_IDLE:  if (arm)    cm_q <= CM_ARMED;
        CM_ARMED: if (commit) cm_q <= CM_IDLE;
        default:              cm_q <= CM_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign period_o  = period_act;
  assign ch_en_o   = ch_en_q;
`ifdef PWM_WB_IRQ_EN
  assign irq_o = done_q & ctrl_q[CTRL_IRQ_EN];
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_wb_regfile.sv
// Directed bench for pwm_wb_regfile: bus map, commit timing, clamp, IMM mode, IRQ and out-of-window access.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_wb_regfile;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]   sel = 4'h0;
  logic [31:0]  wdat = 32'h0, adr = 32'h0;
  logic         ack;
  logic [31:0]  rdat;
  logic         pend = 1'b0;
  logic [15:0]  period;
  logic [127:0] duty;
  logic [7:0]   ch_en;
  logic         irq;

  int checks = 0;
  int errors = 0;

  pwm_wb_regfile dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .wbs_stb_i    (stb),
    .wbs_cyc_i    (cyc),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_dat_i    (wdat),
    .wbs_adr_i    (adr),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (rdat),
    .period_end_i (pend),
    .period_o     (period),
    .duty_o       (duty),
    .ch_en_o      (ch_en),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus access, optionally with period_end_i high in the hit cycle; gives up after 8 cycles
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      input logic pe, output logic [31:0] rv, output logic got);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s; pend = pe;
    got = 1'b0; rv = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      pend = 1'b0;
      if (ack) begin
        got = 1'b1;
        rv  = rdat;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s, input logic pe);
    logic [31:0] rv;
    logic        got;
    xfer(BASE + 32'(o), 1'b1, d, s, pe, rv, got);
    chk("wr_ack", 64'(got), 64'd1);
  endtask

  task automatic wb_rd(input string tag, input logic [7:0] o, input logic [31:0] exp);
    logic [31:0] rv;
    logic        got;
    xfer(BASE + 32'(o), 1'b0, 32'h0, 4'hF, 1'b0, rv, got);
    chk({tag, "_ack"}, 64'(got), 64'd1);
    chk(tag, 64'(rv), 64'(exp));
  endtask

  task automatic pulse();
    pend = 1'b1;
    @(posedge clk); #1;
    pend = 1'b0;
  endtask

  initial begin
    logic [31:0] rv;
    logic        got;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_period", 64'(period), 64'd0);
    chk("rst_duty", duty[63:0], 64'd0);
    chk("rst_chen", 64'(ch_en), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_dat", 64'(rdat), 64'd0);
    rst_n = 1'b1;
    wb_rd("rst_status", 8'h0C, 32'h0);

    // Basic commit on a period boundary
    wb_wr(8'h04, 32'd1000, 4'hF, 1'b0);
    wb_wr(8'h10, 32'd250, 4'hF, 1'b0);
    wb_wr(8'h00, 32'h101, 4'hF, 1'b0);
    wb_wr(8'h08, 32'h1, 4'hF, 1'b0);
    @(posedge clk); #1;
    chk("ack_single", 64'(ack), 64'd0);
    chk("dat_idle", 64'(rdat), 64'd0);
    wb_rd("status_pend", 8'h0C, 32'h2);
    chk("no_commit_yet", 64'(period), 64'd0);
    pulse();
    chk("commit_period", 64'(period), 64'd1000);
    chk("commit_duty0", 64'(duty[15:0]), 64'd250);
    chk("chen_gen", 64'(ch_en), 64'h01);
    wb_rd("status_done", 8'h0C, 32'h1);
    wb_rd("ctrl_rd", 8'h00, 32'h101);

    // DONE W1C, then arm in the same cycle as period_end_i
    wb_wr(8'h0C, 32'h1, 4'hF, 1'b0);
    wb_rd("status_w1c", 8'h0C, 32'h0);
    wb_wr(8'h04, 32'd600, 4'hF, 1'b0);
    wb_wr(8'h08, 32'h1, 4'hF, 1'b1);
    chk("same_cycle_hold", 64'(period), 64'd1000);
    wb_rd("same_cycle_pend", 8'h0C, 32'h2);
    pulse();
    chk("second_pulse", 64'(period), 64'd600);
    chk("duty0_kept", 64'(duty[15:0]), 64'd250);

    // Clamp of an oversized duty, and truncation of a wide write
    wb_wr(8'h04, 32'd500, 4'hF, 1'b0);
    wb_wr(8'h1C, 32'h0001_FFFF, 4'hF, 1'b0);
    wb_wr(8'h08, 32'h1, 4'hF, 1'b0);
    pulse();
    chk("clamp_period", 64'(period), 64'd500);
    chk("clamp_duty3", 64'(duty[63:48]), 64'd500);
    wb_rd("duty3_trunc", 8'h1C, 32'h0000_FFFF);

    // Byte-select write: only the low byte of PERIOD changes (0x01F4 -> 0x01AB)
    wb_wr(8'h04, 32'h0000_12AB, 4'b0001, 1'b0);
    wb_rd("period_bytesel", 8'h04, 32'h0000_01AB);
    chk("active_untouched", 64'(period), 64'd500);

    // Unmapped offset in window reads zero; outside the window is never acked
    wb_rd("unmapped", 8'h30, 32'h0);
    xfer(BASE + 32'h100, 1'b0, 32'h0, 4'hF, 1'b0, rv, got);
    chk("out_of_window", 64'(got), 64'd0);

    // GEN=0: channel enables drop one cycle after the ack; commit needs no boundary
    wb_wr(8'h00, 32'h0, 4'hF, 1'b0);
    chk("chen_before", 64'(ch_en), 64'h01);
    @(posedge clk); #1;
    chk("chen_after", 64'(ch_en), 64'h00);
    wb_wr(8'h0C, 32'h1, 4'hF, 1'b0);
    wb_wr(8'h08, 32'h1, 4'hF, 1'b0);
    chk("gen0_wait", 64'(period), 64'd500);
    @(posedge clk); #1;
    chk("gen0_period", 64'(period), 64'h1AB);
    chk("gen0_duty3", 64'(duty[63:48]), 64'h1AB);
    wb_rd("gen0_status", 8'h0C, 32'h1);

    // IMM: DUTY1 reaches the output two edges after the hit
    wb_wr(8'h00, 32'h2, 4'hF, 1'b0);
    wb_wr(8'h14, 32'd77, 4'hF, 1'b0);
    chk("imm_edge1", 64'(duty[31:16]), 64'd0);
    @(posedge clk); #1;
    chk("imm_edge2", 64'(duty[31:16]), 64'd77);

    // Commit interrupt and its clear
    wb_wr(8'h00, 32'h5, 4'hF, 1'b0);
    wb_wr(8'h0C, 32'h1, 4'hF, 1'b0);
    chk("irq_clear0", 64'(irq), 64'd0);
    wb_wr(8'h08, 32'h1, 4'hF, 1'b0);
    pulse();
`ifdef PWM_WB_IRQ_EN
    chk("irq_set", 64'(irq), 64'd1);
    wb_rd("ctrl_irq_en", 8'h00, 32'h5);
`else
    chk("irq_tied", 64'(irq), 64'd0);
    wb_rd("ctrl_irq_en", 8'h00, 32'h1);
`endif
    wb_rd("irq_done", 8'h0C, 32'h1);
    wb_wr(8'h0C, 32'h1, 4'hF, 1'b0);
    @(posedge clk); #1;
    chk("irq_w1c", 64'(irq), 64'd0);

    // Reset discards an armed commit
    wb_wr(8'h04, 32'd900, 4'hF, 1'b0);
    wb_wr(8'h08, 32'h1, 4'hF, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst2_period", 64'(period), 64'd0);
    chk("rst2_chen", 64'(ch_en), 64'd0);
    pulse();
    chk("rst2_no_commit", 64'(period), 64'd0);
    wb_rd("rst2_status", 8'h0C, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
